// File: rtl/ysyx_24100029_wbu.sv
// ============================================================================
// Module   : ysyx_24100029_wbu
// Brief    : Write-back stage. Latches the LSU payload, retires one
//            instruction per cycle, and drives the RF/CSR write ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24100029_wbu (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] Ex_result,
  input  logic [31:0] csrs,
  input  logic [31:0] LSU_Rdata,
  input  logic [4:0]  rd,
  input  logic        R_wen,
  input  logic [3:0]  csr_wen,
  input  logic        mem_ren,
  input  logic        jump_flag,
  input  logic        valid_last,
  output logic        ready_last,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  csr_we,
  output logic [31:0] csr_wdata,
  output logic        commit,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_jump,
  output logic [63:0] minstret
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_commit;

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_ex_result;
  logic [31:0] r_csrs;
  logic [31:0] r_lsu_rdata;
  logic [4:0]  r_rd;
  logic        r_r_wen;
  logic [3:0]  r_csr_wen;
  logic        r_mem_ren;
  logic        r_jump_flag;
  logic [63:0] r_minstret;

  assign ready_last = 1'b1;
  assign w_accept   = valid_last & ready_last;
  assign w_commit   = (r_state == ST_COMMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_state_next = ST_COMMIT;
      ST_COMMIT: if (!w_accept) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= 32'd0;
      r_inst      <= 32'd0;
      r_ex_result <= 32'd0;
      r_csrs      <= 32'd0;
      r_lsu_rdata <= 32'd0;
      r_rd        <= 5'd0;
      r_r_wen     <= 1'b0;
      r_csr_wen   <= 4'd0;
      r_mem_ren   <= 1'b0;
      r_jump_flag <= 1'b0;
    end else if (w_accept) begin
      r_pc        <= pc;
      r_inst      <= inst;
      r_ex_result <= Ex_result;
      r_csrs      <= csrs;
      r_lsu_rdata <= LSU_Rdata;
      r_rd        <= rd;
      r_r_wen     <= R_wen;
      r_csr_wen   <= csr_wen;
      r_mem_ren   <= mem_ren;
      r_jump_flag <= jump_flag;
    end
  end

  // Reset takes priority, so a retirement caught by reset is never counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_minstret <= 64'd0;
    end else if (w_commit) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  // Loads return memory data; CSR ops write the old CSR value to rd.
  always_comb begin
    rf_wdata = r_ex_result;
    if (r_mem_ren) begin
      rf_wdata = r_lsu_rdata;
    end else if (r_csr_wen != 4'd0) begin
      rf_wdata = r_csrs;
    end
  end

  assign commit      = w_commit;
  assign rf_wen      = w_commit & r_r_wen & (r_rd != 5'd0);
  assign rf_waddr    = r_rd;
  assign csr_we      = w_commit ? r_csr_wen : 4'd0;
  assign csr_wdata   = r_ex_result;
  assign commit_pc   = r_pc;
  assign commit_inst = r_inst;
  assign commit_jump = r_jump_flag;
  assign minstret    = r_minstret;

endmodule

`default_nettype wire
